// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types, constants and ROM address helper for the maze game logic
package maze_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CHECK, S_WIN} state_e;
  typedef enum logic [2:0] {UP, DOWN, LEFT, RIGHT, NONE} dir_e;

  localparam int BLOCK_SIZE = 16;
  localparam int ROM_ADDR_W = 11;

  // Maze ROM is laid out column-major with 32 row slots per column.
  function automatic logic [ROM_ADDR_W-1:0] blk_addr(input logic [5:0] col, input logic [4:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - direction priority, key edge detection and held-key auto-repeat
module key_repeat
  import maze_pkg::*;
#(
  parameter int REPEAT_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_control,
  input  logic       i_frame_tick,
  input  logic       i_accept,
  input  logic       i_restart,
  output logic       o_req,
  output dir_e       o_dir
);

  localparam int CW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(REPEAT_FRAMES - 1);

  logic [3:0]    ctrl_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    win_bit;
  logic          key_edge, held, rpt;

  always_comb begin
    o_dir   = NONE;
    win_bit = 4'b0000;
    if (i_control[3]) begin
      o_dir   = UP;
      win_bit = 4'b1000;
    end else if (i_control[2]) begin
      o_dir   = DOWN;
      win_bit = 4'b0100;
    end else if (i_control[1]) begin
      o_dir   = LEFT;
      win_bit = 4'b0010;
    end else if (i_control[0]) begin
      o_dir   = RIGHT;
      win_bit = 4'b0001;
    end
  end

  assign key_edge = |(win_bit & ~ctrl_q);
  assign held     = (o_dir != NONE) && (i_control == ctrl_q);
  // Counter saturates on its last value so a rejected repeat retries on the next tick.
  assign rpt      = held && i_frame_tick && (cnt_q == CNT_LAST);
  assign o_req    = !i_restart && (key_edge || rpt);

  always_comb begin
    cnt_d = cnt_q;
    if (i_restart || i_accept || !held) begin
      cnt_d = '0;
    end else if (i_frame_tick && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= 4'b0000;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= i_control;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/maze_ctrl.sv
// rtl/maze_ctrl.sv - player/exit position owner with ROM wall check and win detection
module maze_ctrl
  import maze_pkg::*;
#(
  parameter int          MAZE_COLS     = 40,
  parameter int          MAZE_ROWS     = 30,
  parameter int          START_BCOL    = 1,
  parameter int          START_BROW    = 1,
  parameter int          EXIT_BCOL     = 38,
  parameter int          EXIT_BROW     = 28,
  parameter logic [15:0] WALL_VALUE    = 16'h0000,
  parameter int          REPEAT_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            i_control,
  input  logic                  i_frame_tick,
  input  logic                  i_restart,
  output logic                  o_rom_en,
  output logic [ROM_ADDR_W-1:0] o_rom_addr,
  input  logic [15:0]           i_rom_data,
  output logic [5:0]            o_player_bcol,
  output logic [5:0]            o_player_brow,
  output logic [5:0]            o_exit_bcol,
  output logic [5:0]            o_exit_brow,
  output logic                  o_win
);

  localparam logic [5:0] MAX_COL = 6'(MAZE_COLS - 1);
  localparam logic [5:0] MAX_ROW = 6'(MAZE_ROWS - 1);
  localparam logic [5:0] START_C = 6'(START_BCOL);
  localparam logic [5:0] START_R = 6'(START_BROW);
  localparam logic [5:0] EXIT_C  = 6'(EXIT_BCOL);
  localparam logic [5:0] EXIT_R  = 6'(EXIT_BROW);

  state_e     state_q, state_d;
  logic [5:0] player_col_q, player_row_q;
  logic [5:0] tgt_col_q, tgt_row_q, tgt_col_d, tgt_row_d;
  logic [5:0] exit_col_q, exit_row_q;
  logic [5:0] new_col, new_row;
  logic       req, in_bounds, accept, at_exit;
  dir_e       dir;

  key_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_keys (
    .clk          (clk),
    .rst          (rst),
    .i_control    (i_control),
    .i_frame_tick (i_frame_tick),
    .i_accept     (accept),
    .i_restart    (i_restart),
    .o_req        (req),
    .o_dir        (dir)
  );

  always_comb begin
    tgt_col_d = player_col_q;
    tgt_row_d = player_row_q;
    in_bounds = 1'b0;
    case (dir)
      UP: begin
        in_bounds = (player_row_q != 6'd0);
        tgt_row_d = player_row_q - 6'd1;
      end
      DOWN: begin
        in_bounds = (player_row_q < MAX_ROW);
        tgt_row_d = player_row_q + 6'd1;
      end
      LEFT: begin
        in_bounds = (player_col_q != 6'd0);
        tgt_col_d = player_col_q - 6'd1;
      end
      RIGHT: begin
        in_bounds = (player_col_q < MAX_COL);
        tgt_col_d = player_col_q + 6'd1;
      end
      default: in_bounds = 1'b0;
    endcase
  end

  assign accept  = (state_q == S_IDLE) && req && in_bounds;
  assign new_col = (i_rom_data == WALL_VALUE) ? player_col_q : tgt_col_q;
  assign new_row = (i_rom_data == WALL_VALUE) ? player_row_q : tgt_row_q;
  assign at_exit = (new_col == exit_col_q) && (new_row == exit_row_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_restart) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_REQ;
        S_REQ:   state_d = S_CHECK;
        S_CHECK: state_d = at_exit ? S_WIN : S_IDLE;
        S_WIN:   state_d = S_WIN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_rom_en   = (state_q == S_REQ);
    o_rom_addr = o_rom_en ? blk_addr(tgt_col_q, tgt_row_q[4:0]) : '0;
    o_win      = (state_q == S_WIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      player_col_q <= START_C;
      player_row_q <= START_R;
      tgt_col_q    <= START_C;
      tgt_row_q    <= START_R;
    end else if (i_restart) begin
      player_col_q <= START_C;
      player_row_q <= START_R;
    end else begin
      if (accept) begin
        tgt_col_q <= tgt_col_d;
        tgt_row_q <= tgt_row_d;
      end
      if (state_q == S_CHECK) begin
        player_col_q <= new_col;
        player_row_q <= new_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exit_col_q <= EXIT_C;
      exit_row_q <= EXIT_R;
    end
  end

  assign o_player_bcol = player_col_q;
  assign o_player_brow = player_row_q;
  assign o_exit_bcol   = exit_col_q;
  assign o_exit_brow   = exit_row_q;

endmodule

// File: tb/tb_maze_ctrl.sv
// tb/tb_maze_ctrl.sv - directed self-checking bench for maze_ctrl
module tb_maze_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ctrl = 4'b0000;
  logic        tick = 1'b0;
  logic        restart = 1'b0;
  logic        rom_en;
  logic [10:0] rom_addr;
  logic [15:0] rom_data = 16'hBEEF;
  logic [5:0]  pcol, prow, ecol, erow;
  logic        win;

  logic [10:0] wall_addr = 11'h7FF;
  int          en_cnt = 0;
  int          en_snap;
  int          n_checks = 0;
  int          n_fail = 0;

  maze_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_control     (ctrl),
    .i_frame_tick  (tick),
    .i_restart     (restart),
    .o_rom_en      (rom_en),
    .o_rom_addr    (rom_addr),
    .i_rom_data    (rom_data),
    .o_player_bcol (pcol),
    .o_player_brow (prow),
    .o_exit_bcol   (ecol),
    .o_exit_brow   (erow),
    .o_win         (win)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data <= (rom_en && rom_addr == wall_addr) ? 16'h0000 : 16'hBEEF;
    if (rom_en) en_cnt <= en_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic move(input logic [3:0] c);
    ctrl = c;
    step();
    ctrl = 4'b0000;
    step();
    step();
    step();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_pcol", pcol, 1);
    chk("rst_prow", prow, 1);
    chk("rst_ecol", ecol, 38);
    chk("rst_erow", erow, 28);
    chk("rst_win", win, 0);
    chk("rst_en", rom_en, 0);
    chk("rst_addr", rom_addr, 0);
    rst = 1'b1;
    step();

    // Single move right with latency
    en_snap = en_cnt;
    ctrl = 4'b0001;
    step();
    chk("t1_en", rom_en, 1);
    chk("t1_addr", rom_addr, 65);
    chk("t1_pcol_early", pcol, 1);
    ctrl = 4'b0000;
    step();
    chk("t1_en_off", rom_en, 0);
    chk("t1_pcol_mid", pcol, 1);
    step();
    chk("t1_pcol", pcol, 2);
    chk("t1_prow", prow, 1);
    step();
    chk("t1_en_cnt", en_cnt - en_snap, 1);

    // Wall above start blocks the move
    do_restart();
    chk("t2_restart_col", pcol, 1);
    wall_addr = 11'd32;
    en_snap = en_cnt;
    ctrl = 4'b1000;
    step();
    chk("t2_en", rom_en, 1);
    chk("t2_addr", rom_addr, 32);
    ctrl = 4'b0000;
    step();
    step();
    step();
    chk("t2_pcol", pcol, 1);
    chk("t2_prow", prow, 1);
    chk("t2_en_cnt", en_cnt - en_snap, 1);
    wall_addr = 11'h7FF;

    // Left edge rejected without ROM access
    move(4'b0010);
    for (int i = 0; i < 4; i++) move(4'b0100);
    chk("t3_setup_col", pcol, 0);
    chk("t3_setup_row", prow, 5);
    en_snap = en_cnt;
    ctrl = 4'b0010;
    step();
    chk("t3_en", rom_en, 0);
    step();
    step();
    ctrl = 4'b0000;
    step();
    chk("t3_en_cnt", en_cnt - en_snap, 0);
    chk("t3_pcol", pcol, 0);
    chk("t3_prow", prow, 5);

    // Held key auto-repeat over 20 frame ticks
    do_restart();
    en_snap = en_cnt;
    ctrl = 4'b0100;
    step();
    step();
    step();
    step();
    chk("t4_edge_row", prow, 2);
    for (int i = 1; i <= 20; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      step();
      step();
      if (i == 7) chk("t4_row_at7", prow, 2);
      if (i == 8) chk("t4_row_at8", prow, 3);
    end
    ctrl = 4'b0000;
    step();
    chk("t4_row", prow, 4);
    chk("t4_col", pcol, 1);
    chk("t4_en_cnt", en_cnt - en_snap, 3);

    // Walk to the exit and win
    do_restart();
    for (int i = 0; i < 36; i++) move(4'b0001);
    for (int i = 0; i < 27; i++) move(4'b0100);
    chk("t5_pre_col", pcol, 37);
    chk("t5_pre_row", prow, 28);
    chk("t5_pre_win", win, 0);
    ctrl = 4'b0001;
    step();
    ctrl = 4'b0000;
    step();
    step();
    chk("t5_win", win, 1);
    chk("t5_pcol", pcol, 38);
    en_snap = en_cnt;
    move(4'b1000);
    move(4'b0010);
    chk("t5_win_hold", win, 1);
    chk("t5_frozen_row", prow, 28);
    chk("t5_frozen_en", en_cnt - en_snap, 0);
    do_restart();
    chk("t5_rs_win", win, 0);
    chk("t5_rs_col", pcol, 1);
    chk("t5_rs_row", prow, 1);

    // Restart during ROM access discards the result
    step();
    ctrl = 4'b0001;
    step();
    chk("t6_en", rom_en, 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("t6_en_off", rom_en, 0);
    en_snap = en_cnt;
    step();
    step();
    step();
    chk("t6_pcol", pcol, 1);
    chk("t6_prow", prow, 1);
    chk("t6_no_spurious", en_cnt - en_snap, 0);
    ctrl = 4'b0000;
    step();

    // Simultaneous up+left: up wins
    ctrl = 4'b1010;
    step();
    chk("t7_addr", rom_addr, 32);
    step();
    step();
    chk("t7_prow", prow, 0);
    chk("t7_pcol", pcol, 1);
    ctrl = 4'b0000;
    step();

    // Asynchronous reset mid-access
    ctrl = 4'b0001;
    step();
    chk("t8_en", rom_en, 1);
    rst = 1'b0;
    #1;
    chk("t8_en_off", rom_en, 0);
    chk("t8_pcol", pcol, 1);
    chk("t8_prow", prow, 1);
    ctrl = 4'b0000;
    step();
    rst = 1'b1;
    step();
    chk("t8_after_col", pcol, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
